pulse_height_histogram: RTL and testbench

- Sits directly downstream of the level-trigger integrator and consumes its per-pulse SUM_WIDTH sums on an AXI-Stream slave.
- Maps each sum to a bin and increments that bin's counter in block RAM, using a pipelined read-modify-write.
- On request, streams the whole histogram out on an AXI-Stream master for DMA to the host.

---
 rtl/pulse_analyzer_pkg.sv | 17 +
 rtl/hist_bin_ram.sv | 25 ++
 rtl/pulse_height_histogram.sv | 227 ++++++++++++++++++++++
 tb/tb_pulse_height_histogram.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_analyzer_pkg.sv
// Shared state encoding and default sizing for the pulse-height histogram path.
package pulse_analyzer_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DUMP  = 2'd3
   } hist_state_t;

   localparam int DEF_BIN_BITS    = 10;
   localparam int DEF_COUNT_WIDTH = 32;

   // Counters stop here instead of wrapping.
   localparam logic [DEF_COUNT_WIDTH-1:0] SAT_MAX = {DEF_COUNT_WIDTH{1'b1}};

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port bin RAM: one write port, one read port with a registered
// (1-cycle) read. A read of the address being written returns the old value.
module hist_bin_ram #(
   parameter int ADDR_BITS  = 10,
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

   // Write port and registered read port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/pulse_height_histogram.sv
// Pulse-height histogram: bins integrator sums into saturating RAM counters and
// streams the histogram out on request. PULSE_HIST_CLEAR_ON_DUMP_EN zeroes bins as they are dumped.
module pulse_height_histogram
   import pulse_analyzer_pkg::*;
#(
   parameter int SUM_WIDTH   = 32,
   parameter int BIN_BITS    = DEF_BIN_BITS,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int SHIFT_WIDTH = 5
)(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [SUM_WIDTH-1:0]   bin_offset,
   input  logic [SHIFT_WIDTH-1:0] bin_shift,
   input  logic                   dump_start,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [SUM_WIDTH-1:0]   s_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [COUNT_WIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   output logic                   busy,
   output logic                   sat_err
);

   localparam logic [BIN_BITS-1:0]    ADDR_LAST = {BIN_BITS{1'b1}};
   localparam logic [BIN_BITS-1:0]    ADDR_ONE  = BIN_BITS'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = COUNT_WIDTH'(SAT_MAX);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

   hist_state_t state, state_nxt;

   logic [BIN_BITS-1:0]    addr;
   logic                   addr_done;
   logic [SUM_WIDTH-1:0]   diff, shifted;
   logic [BIN_BITS-1:0]    idx;
   logic                   accept, out_free, rd_issue, last_hs;
   logic                   s1_valid, s2_valid, s2_sat, lw_valid;
   logic [BIN_BITS-1:0]    s1_idx, s2_idx, lw_addr;
   logic [COUNT_WIDTH-1:0] s2_count, lw_data, fwd;
   logic                   rd_pend, rd_pend_last;
   logic                   sk_valid, sk_last;
   logic [COUNT_WIDTH-1:0] sk_data;
   logic                   ram_we;
   logic [BIN_BITS-1:0]    ram_waddr, ram_raddr;
   logic [COUNT_WIDTH-1:0] ram_wdata, ram_rdata;
`ifdef PULSE_HIST_CLEAR_ON_DUMP_EN
   logic [BIN_BITS-1:0]    rd_pend_addr;
`endif

   assign accept   = s_tvalid & s_tready;
   assign out_free = ~m_tvalid | m_tready;
   // No new read while the skid slot is occupied, so at most one word can land in it.
   assign rd_issue = (state == ST_DUMP) & ~addr_done & out_free & ~sk_valid;
   assign last_hs  = m_tvalid & m_tready & m_tlast;
   assign ram_raddr = (state == ST_DUMP) ? addr : idx;

   // Sum to bin index: underflow maps to bin 0, overflow clamps to the top bin.
   always_comb begin
      diff    = s_tdata - bin_offset;
      shifted = diff >> bin_shift;
      if (s_tdata < bin_offset) begin
         idx = '0;
      end else if (|shifted[SUM_WIDTH-1:BIN_BITS]) begin
         idx = ADDR_LAST;
      end else begin
         idx = shifted[BIN_BITS-1:0];
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (addr == ADDR_LAST) state_nxt = ST_ACCUM; else state_nxt = ST_CLEAR;
         ST_ACCUM: if (dump_start) state_nxt = ST_DRAIN; else state_nxt = ST_ACCUM;
         ST_DRAIN: if (!s1_valid && !s2_valid) state_nxt = ST_DUMP; else state_nxt = ST_DRAIN;
         ST_DUMP:  if (last_hs) state_nxt = ST_ACCUM; else state_nxt = ST_DUMP;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   // RAM write port: clear pass, accumulate write-back, or clear-behind during dump.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = s2_idx;
      ram_wdata = s2_count;
      case (state)
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = addr;
            ram_wdata = '0;
         end
         ST_ACCUM, ST_DRAIN: ram_we = s2_valid;
         ST_DUMP: begin
`ifdef PULSE_HIST_CLEAR_ON_DUMP_EN
            ram_we    = rd_pend;
            ram_waddr = rd_pend_addr;
            ram_wdata = '0;
`else
            ram_we    = 1'b0;
`endif
         end
         default: ram_we = 1'b0;
      endcase
   end

   // Newest value of the bin being read: the write in progress, then last cycle's write, then RAM.
   always_comb begin
      if (ram_we && (ram_waddr == s1_idx)) begin
         fwd = ram_wdata;
      end else if (lw_valid && (lw_addr == s1_idx)) begin
         fwd = lw_data;
      end else begin
         fwd = ram_rdata;
      end
   end

   // FSM state, address counter, RMW pipeline and status flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_CLEAR;
         addr         <= '0;
         addr_done    <= 1'b0;
         s1_valid     <= 1'b0;
         s1_idx       <= '0;
         s2_valid     <= 1'b0;
         s2_idx       <= '0;
         s2_count     <= '0;
         s2_sat       <= 1'b0;
         lw_valid     <= 1'b0;
         lw_addr      <= '0;
         lw_data      <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         s_tready     <= 1'b0;
         busy         <= 1'b1;
         sat_err      <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_CLEAR: addr <= addr + ADDR_ONE;
            ST_DUMP: begin
               if (rd_issue) begin
                  addr <= addr + ADDR_ONE;
                  if (addr == ADDR_LAST) addr_done <= 1'b1;
               end
            end
            default: begin
               addr      <= '0;
               addr_done <= 1'b0;
            end
         endcase
         s1_valid     <= accept;
         s1_idx       <= idx;
         s2_valid     <= s1_valid;
         s2_idx       <= s1_idx;
         s2_sat       <= (fwd == CNT_MAX);
         s2_count     <= (fwd == CNT_MAX) ? fwd : fwd + CNT_ONE;
         lw_valid     <= ram_we;
         lw_addr      <= ram_waddr;
         lw_data      <= ram_wdata;
         rd_pend      <= rd_issue;
         rd_pend_last <= rd_issue & (addr == ADDR_LAST);
         s_tready     <= (state_nxt == ST_ACCUM);
         busy         <= (state_nxt != ST_ACCUM);
         sat_err      <= sat_err | (s2_valid & s2_sat);
      end
   end

`ifdef PULSE_HIST_CLEAR_ON_DUMP_EN
   // Remember which bin the arriving read word belongs to so it can be zeroed.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_pend_addr <= '0;
      end else begin
         rd_pend_addr <= addr;
      end
   end
`endif

   // Output register with one skid slot behind it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
         sk_valid <= 1'b0;
         sk_data  <= '0;
         sk_last  <= 1'b0;
      end else if (out_free) begin
         if (sk_valid) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sk_data;
            m_tlast  <= sk_last;
            sk_valid <= 1'b0;
         end else if (rd_pend) begin
            m_tvalid <= 1'b1;
            m_tdata  <= ram_rdata;
            m_tlast  <= rd_pend_last;
         end else begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
         end
      end else if (rd_pend) begin
         sk_valid <= 1'b1;
         sk_data  <= ram_rdata;
         sk_last  <= rd_pend_last;
      end else begin
         sk_valid <= sk_valid;
      end
   end

   hist_bin_ram #(
      .ADDR_BITS  (BIN_BITS),
      .DATA_WIDTH (COUNT_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_pulse_height_histogram.sv
// Scoreboard bench for pulse_height_histogram (16 bins, 6-bit counters).
`timescale 1ns/1ps
module tb_pulse_height_histogram;

   localparam int SW   = 32;
   localparam int BB   = 4;
   localparam int CW   = 6;
   localparam int SHW  = 5;
   localparam int N    = 1 << BB;
   localparam int MAXC = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           resetn;
   logic [SW-1:0]  bin_offset;
   logic [SHW-1:0] bin_shift;
   logic           dump_start;
   logic           s_tvalid;
   logic           s_tready;
   logic [SW-1:0]  s_tdata;
   logic           m_tvalid;
   logic           m_tready;
   logic [CW-1:0]  m_tdata;
   logic           m_tlast;
   logic           busy;
   logic           sat_err;

   always #5 clk = ~clk;

   pulse_height_histogram #(
      .SUM_WIDTH(SW), .BIN_BITS(BB), .COUNT_WIDTH(CW), .SHIFT_WIDTH(SHW)
   ) dut (
      .clk(clk), .resetn(resetn), .bin_offset(bin_offset), .bin_shift(bin_shift),
      .dump_start(dump_start), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .busy(busy), .sat_err(sat_err)
   );

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   int   model[N];
   bit   model_sat = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   rand_ready = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference binning straight from the arithmetic definition.
   function automatic int bin_of(input longint s, input longint o, input int sh);
      longint d;
      if (s < o) return 0;
      d = (s - o) >> sh;
      if (d > N - 1) return N - 1;
      return int'(d);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [SW-1:0] v);
      int guard;
      bit acc;
      guard = 0;
      acc = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = v;
      while (!acc && guard < 1000) begin
         acc = s_tready;
         tick();
         guard++;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      while ((busy || exp_q.size() != 0) && guard < 5000) begin
         tick();
         guard++;
      end
      if (guard >= 5000) chk(name, exp_q.size(), 0);
   endtask

   task automatic do_dump();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      chk("tready_low_after_dump", s_tready, 0);
      wait_idle("dump_timeout");
      chk("busy_after_dump", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) model[i] = 0;
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Monitor: model update on accepted sums, snapshot on honoured dump, compare on output handshakes.
   always @(negedge clk) begin
      int b;
      exp_t e;
      if (resetn) begin
         if (s_tvalid && s_tready) begin
            b = bin_of(longint'(s_tdata), longint'(bin_offset), int'(bin_shift));
            if (model[b] == MAXC) model_sat = 1'b1;
            else model[b] = model[b] + 1;
         end
         if (dump_start && !busy) begin
            for (int i = 0; i < N; i++) begin
               e.data = model[i];
               e.last = (i == N - 1);
               exp_q.push_back(e);
`ifdef PULSE_HIST_CLEAR_ON_DUMP_EN
               model[i] = 0;
`endif
            end
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", m_tdata, -1);
            end else begin
               e = exp_q.pop_front();
               chk("bin_count", m_tdata, e.data);
               chk("bin_last", m_tlast, e.last);
            end
         end
         if (busy) chk("tready_while_busy", s_tready, 0);
      end
   end

   initial begin
      int n;
      resetn     = 1'b0;
      bin_offset = '0;
      bin_shift  = '0;
      dump_start = 1'b0;
      s_tvalid   = 1'b0;
      s_tdata    = '0;
      repeat (3) tick();
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_busy", busy, 1);
      chk("rst_sat_err", sat_err, 0);
      resetn = 1'b1;

      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("clear_cycles", n, N);
      chk("tready_after_clear", s_tready, 1);
      do_dump();

      bin_offset = 32'd100;
      bin_shift  = 5'd2;
      send(32'd100); send(32'd103); send(32'd104); send(32'd99); send(32'd1_000_000);
      s_tvalid = 1'b0;
      do_dump();

      bin_offset = 32'd0;
      bin_shift  = 5'd4;
      repeat (50) send(32'd200);
      s_tvalid = 1'b0;
      do_dump();

      rand_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         bin_offset = $urandom_range(0, 300);
         bin_shift  = 5'($urandom_range(0, 6));
         for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 2000));
            if ($urandom_range(0, 2) == 0) begin
               s_tvalid = 1'b0;
               tick();
            end
         end
         s_tvalid = 1'b0;
         do_dump();
      end

      bin_offset = 32'd0;
      bin_shift  = 5'd0;
      send(32'd5);
      send(32'd6);
      s_tvalid   = 1'b1;
      s_tdata    = 32'd7;
      dump_start = 1'b1;
      tick();
      s_tdata    = 32'd9;
      chk("inflight_tready_low", s_tready, 0);
      tick();
      dump_start = 1'b0;
      wait_idle("inflight_dump_timeout");
      send(32'd9);
      s_tvalid = 1'b0;

      repeat (70) send(32'd3);
      s_tvalid = 1'b0;
      repeat (4) tick();
      chk("sat_err_set", sat_err, model_sat);
      do_dump();
      chk("sat_err_sticky", sat_err, 1);
      do_dump();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
